// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) helpers, word type and expander state enum.
// Also carries the InvMixColumns helper used when AES_KEYEXP_EQINV_EN is defined.
package aes_pkg;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } aes_state_e;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;

  // Entry b sits at bits [8*(255-b) +: 8]; row 0 is the most significant 128 bits.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return AES_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t inv_mix_word(input aes_word_t w);
    logic [7:0] b   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int k = 0; k < 4; k++) begin
      b[k]   = w[31-8*k -: 8];
      x2[k]  = xtime(b[k]);
      x4[k]  = xtime(x2[k]);
      x8[k]  = xtime(x4[k]);
      m9[k]  = x8[k] ^ b[k];
      m11[k] = x8[k] ^ x2[k] ^ b[k];
      m13[k] = x8[k] ^ x4[k] ^ b[k];
      m14[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  aes_word_t word,
  output aes_word_t sub_word
);

  assign sub_word = {sbox_byte(word[31:24]), sbox_byte(word[23:16]),
                     sbox_byte(word[15:8]),  sbox_byte(word[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: one word per cycle into a flat round-key store.
// Define AES_KEYEXP_EQINV_EN to read middle round keys through InvMixColumns.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter  int NK = 8,
  localparam int NR = NK + 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [NK*32-1:0] key_in,
  output logic            busy,
  output logic            rk_valid,
  input  logic [3:0]      rk_rd_idx,
  output logic [127:0]    rk_rd_data
);

  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_key_expander: NK must be 4, 6 or 8");
  end

  // Handshake: a key is taken on any rising edge where key_valid && key_ready;
  // key_ready is low only during EXPAND, where key_valid is ignored.
  aes_state_e     state, state_nxt;
  logic           accept;
  aes_word_t      w [NW];
  logic [IW-1:0]  wi;
  logic [2:0]     wmod;
  logic [7:0]     rcon;

  aes_word_t      prev_word, far_word, rot_word, sbox_in, sbox_out, temp_word, new_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    rk_valid  = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (wi == IW'(NW - 1)) state_nxt = DONE;
      end
      DONE: begin
        key_ready = 1'b1;
        rk_valid  = 1'b1;
        if (key_valid) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prev_word = w[wi - IW'(1)];
    far_word  = w[wi - IW'(NK)];
    rot_word  = {prev_word[23:0], prev_word[31:24]};
    sbox_in   = (wmod == 3'd0) ? rot_word : prev_word;
    temp_word = prev_word;
    if (wmod == 3'd0)                temp_word = sbox_out ^ {rcon, 24'h0};
    else if (NK == 8 && wmod == 3'd4) temp_word = sbox_out;
    new_word  = far_word ^ temp_word;
  end

  aes_sbox_word u_sbox (
    .word     (sbox_in),
    .sub_word (sbox_out)
  );

  // wmod tracks i mod NK so the Rcon/SubWord positions need no divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wi   <= '0;
      wmod <= '0;
      rcon <= '0;
      for (int j = 0; j < NW; j++) w[j] <= '0;
    end else if (accept) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[NK*32-1-32*j -: 32];
      wi   <= IW'(NK);
      wmod <= '0;
      rcon <= AES_RCON_INIT;
    end else if (state == EXPAND) begin
      w[wi] <= new_word;
      wi    <= wi + IW'(1);
      wmod  <= (wmod == 3'(NK - 1)) ? 3'd0 : wmod + 3'd1;
      if (wmod == 3'd0) rcon <= xtime(rcon);
    end
  end

  logic [IW-1:0] rd_base;
  aes_word_t     rk_word [4];

  always_comb begin
    rd_base    = IW'({rk_rd_idx, 2'b00});
    rk_rd_data = '0;
    for (int k = 0; k < 4; k++) rk_word[k] = w[rd_base + IW'(k)];
    if (rk_rd_idx <= 4'(NR)) begin
      rk_rd_data = {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};
`ifdef AES_KEYEXP_EQINV_EN
      // Equivalent inverse cipher: first and last round keys stay untouched.
      if (rk_rd_idx != 4'd0 && rk_rd_idx != 4'(NR))
        rk_rd_data = {inv_mix_word(rk_word[0]), inv_mix_word(rk_word[1]),
                      inv_mix_word(rk_word[2]), inv_mix_word(rk_word[3])};
`endif
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: NK=4/6/8 instances against a FIPS-197 reference model.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         key_valid [3];
  logic [255:0] key_vec   [3];
  logic [3:0]   rd_idx    [3];
  logic         key_ready [3];
  logic         busy      [3];
  logic         rk_valid  [3];
  logic [127:0] rd_data   [3];

  aes_key_expander #(.NK(4)) u_nk4 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid[0]), .key_ready(key_ready[0]),
    .key_in(key_vec[0][127:0]), .busy(busy[0]), .rk_valid(rk_valid[0]),
    .rk_rd_idx(rd_idx[0]), .rk_rd_data(rd_data[0]));

  aes_key_expander #(.NK(6)) u_nk6 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid[1]), .key_ready(key_ready[1]),
    .key_in(key_vec[1][191:0]), .busy(busy[1]), .rk_valid(rk_valid[1]),
    .rk_rd_idx(rd_idx[1]), .rk_rd_data(rd_data[1]));

  aes_key_expander #(.NK(8)) u_nk8 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid[2]), .key_ready(key_ready[2]),
    .key_in(key_vec[2][255:0]), .busy(busy[2]), .rk_valid(rk_valid[2]),
    .rk_rd_idx(rd_idx[2]), .rk_rd_data(rd_data[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int nk, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s nk=%0d: got %h expected %h", name, nk, act, exp);
    end
  endtask

  // ---------------- reference model (plain GF(2^8) arithmetic) ----------------
  logic [7:0]  m_sbox [256];
  logic [31:0] exp_w  [3][60];
  int          m_left [3] = '{0, 0, 0};
  bit          m_done [3] = '{0, 0, 0};
  bit          m_zero [3] = '{1, 1, 1};

  function automatic int nk_of(input int n);
    return 4 + 2 * n;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return 8'((x << k) | (x >> (8 - k)));
  endfunction

  // S-box from the definition: multiplicative inverse followed by the affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] x);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = x;
    return {gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9),
            gm(a0, 9)  ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13),
            gm(a0, 13) ^ gm(a1, 9)  ^ gm(a2, 14) ^ gm(a3, 11),
            gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9)  ^ gm(a3, 14)};
  endfunction

  function automatic void expand(input int n, input logic [255:0] key);
    int nk = nk_of(n);
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) exp_w[n][i] = key[32*(nk-1-i) +: 32];
      else begin
        t = exp_w[n][i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % nk == 4) t = subw(t);
        exp_w[n][i] = exp_w[n][i-nk] ^ t;
      end
    end
  endfunction

  function automatic logic [127:0] exp_rk(input int n, input int idx);
    int nr = nk_of(n) + 6;
    logic [127:0] r;
    if (idx > nr) return '0;
    r = {exp_w[n][4*idx], exp_w[n][4*idx+1], exp_w[n][4*idx+2], exp_w[n][4*idx+3]};
`ifdef AES_KEYEXP_EQINV_EN
    if (idx != 0 && idx != nr)
      r = {inv_mix_col(r[127:96]), inv_mix_col(r[95:64]),
           inv_mix_col(r[63:32]), inv_mix_col(r[31:0])};
`endif
    return r;
  endfunction

  // Model timeline: a key accepted while idle/done makes rk_valid come back
  // 4*NR+4-NK edges later; anything offered in between is ignored.
  always @(posedge clk or negedge rst_n) begin
    for (int n = 0; n < 3; n++) begin
      if (!rst_n) begin
        m_left[n] = 0;
        m_done[n] = 1'b0;
        m_zero[n] = 1'b1;
      end else if (m_left[n] > 0) begin
        m_left[n] = m_left[n] - 1;
        if (m_left[n] == 0) m_done[n] = 1'b1;
      end else if (key_valid[n] === 1'b1) begin
        expand(n, key_vec[n]);
        m_left[n] = 4 * (nk_of(n) + 6) + 4 - nk_of(n);
        m_done[n] = 1'b0;
        m_zero[n] = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      chk("key_ready", nk_of(n), 128'(key_ready[n]), 128'(m_left[n] == 0));
      chk("busy",      nk_of(n), 128'(busy[n]),      128'(m_left[n] != 0));
      chk("rk_valid",  nk_of(n), 128'(rk_valid[n]),  128'(m_done[n] && m_left[n] == 0));
      if (m_zero[n])
        chk("rd_after_reset", nk_of(n), rd_data[n], 128'h0);
      else if (m_done[n] && m_left[n] == 0)
        chk("rk_rd_data", nk_of(n), rd_data[n], exp_rk(n, int'(rd_idx[n])));
    end
  end

  // ---------------- drivers ----------------
  bit rand_idx = 1'b1;

  always @(posedge clk) begin
    #1;
    if (rand_idx)
      for (int n = 0; n < 3; n++) rd_idx[n] = 4'($urandom_range(0, 15));
  end

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  task automatic load_key(input int n, input logic [255:0] key);
    @(posedge clk); #1;
    key_vec[n]   = key;
    key_valid[n] = 1'b1;
    @(posedge clk); #1;
    key_valid[n] = 1'b0;
  endtask

  // Starts one edge after acceptance, so k equals the edge number rk_valid rose on.
  task automatic wait_valid(input int n, input int exp_edge, input bit noise);
    int k = 0;
    while (rk_valid[n] !== 1'b1 && k < 300) begin
      if (noise) begin
        key_valid[n] = 1'($urandom_range(0, 1));
        key_vec[n]   = rand_key();
      end
      @(posedge clk); #1;
      k++;
    end
    key_valid[n] = 1'b0;
    chk("valid_latency", nk_of(n), 128'(k), 128'(exp_edge));
  endtask

  task automatic read_rk(input int n, input int idx, output logic [127:0] d);
    rand_idx = 1'b0;
    #1;
    rd_idx[n] = 4'(idx);
    #1;
    d = rd_data[n];
    rand_idx = 1'b1;
  endtask

  logic [255:0] fips_key [3];
  logic [127:0] fips_last [3];
  logic [127:0] d;
  logic [255:0] ka, kb;
  int sel;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_key[0]  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_key[1]  = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    fips_key[2]  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    fips_last[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fips_last[1] = 128'he98ba06f448c773c8ecc720401002202;
    fips_last[2] = 128'hfe4890d1e6188d0b046df344706c631e;

    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      key_valid[n] = 1'b0;
      key_vec[n]   = '0;
      rd_idx[n]    = '0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("reset_key_ready", nk_of(n), 128'(key_ready[n]), 128'h1);
      chk("reset_rk_valid",  nk_of(n), 128'(rk_valid[n]),  128'h0);
    end
    rst_n = 1'b1;

    // FIPS-197 vectors on each key size, with literal expectations.
    for (int n = 0; n < 3; n++) begin
      load_key(n, fips_key[n]);
      wait_valid(n, 4 * (nk_of(n) + 6) + 4 - nk_of(n), 1'b0);
      read_rk(n, nk_of(n) + 6, d);
      chk("fips_last_rk", nk_of(n), d, fips_last[n]);
      chk("model_last_rk", nk_of(n), exp_rk(n, nk_of(n) + 6), fips_last[n]);
      read_rk(n, 0, d);
      chk("fips_rk0", nk_of(n), d, 128'(fips_key[n] >> (32 * nk_of(n) - 128)));
    end
    chk("nk4_latency_literal", 4, 128'(4 * 10 + 4 - 4), 128'd40);
    read_rk(0, 15, d);
    chk("idx15_zero", 4, d, 128'h0);
    read_rk(0, 5, d);
    chk("idx5", 4, d, exp_rk(0, 5));
    read_rk(0, 10, d);
    chk("idx10_unchanged", 4, d, fips_last[0]);

    // Key held valid throughout expansion: ignored until DONE.
    ka = rand_key();
    kb = rand_key();
    @(posedge clk); #1;
    key_vec[0]   = ka;
    key_valid[0] = 1'b1;
    @(posedge clk); #1;
    key_vec[0] = kb;
    begin
      int k = 0;
      while (rk_valid[0] !== 1'b1 && k < 300) begin
        chk("hold_key_ready", 4, 128'(key_ready[0]), 128'h0);
        @(posedge clk); #1;
        k++;
      end
      chk("hold_latency", 4, 128'(k), 128'd40);
    end
    read_rk(0, 10, d);
    expand(0, ka);
    chk("hold_first_key", 4, d, exp_rk(0, 10));
    @(posedge clk); #1;
    chk("hold_drop", 4, 128'(rk_valid[0]), 128'h0);
    chk("hold_busy", 4, 128'(busy[0]), 128'h1);
    key_valid[0] = 1'b0;
    wait_valid(0, 40, 1'b0);
    read_rk(0, 10, d);
    expand(0, kb);
    chk("hold_second_key", 4, d, exp_rk(0, 10));

    // Asynchronous reset in the middle of an NK=4 expansion.
    load_key(0, rand_key());
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("midreset_key_ready", nk_of(n), 128'(key_ready[n]), 128'h1);
      chk("midreset_busy",      nk_of(n), 128'(busy[n]),      128'h0);
      chk("midreset_rk_valid",  nk_of(n), 128'(rk_valid[n]),  128'h0);
      chk("midreset_rd_data",   nk_of(n), rd_data[n],         128'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_key(0, rand_key());
    wait_valid(0, 40, 1'b0);

    // Randomized keys with junk offered during expansion.
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 2);
      load_key(sel, rand_key());
      wait_valid(sel, 4 * (nk_of(sel) + 6) + 4 - nk_of(sel), 1'b1);
      repeat ($urandom_range(3, 12)) @(posedge clk);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES key-schedule unit feeding the unrolled inverse-cipher datapath. It accepts a 128/192/256-bit cipher key over a valid/ready handshake and generates one 32-bit schedule word per cycle (FIPS-197 KeyExpansion). It stores all NR+1 round keys in an internal register file. The decryption datapath reads any round key by index once `rk_valid` is high, in whatever order it needs (NR down to 0 for decryption).

## Interface
- `NK`, 8: key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
- `NR`, NK+6: number of rounds; derived, never overridden.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  `key_in` is valid.
- `key_ready`  out  1  block can accept a key.
- `key_in`  in  NK*32  cipher key; bits [NK*32-1 -: 32] are w[0] (FIPS byte order).
- `busy`  out  1  expansion in progress.
- `rk_valid`  out  1  all round keys for the last accepted key are stored.
- `rk_rd_idx`  in  4  round-key index, 0..NR.
- `rk_rd_data`  out  128  round key {w[4i], w[4i+1], w[4i+2], w[4i+3]}, with w[4i] in [127:96]; combinational from storage.

## Operation
- States:
  - IDLE: `key_ready`=1, `busy`=0, `rk_valid`=0.
  - EXPAND: `key_ready`=0, `busy`=1.
  - DONE: `key_ready`=1, `busy`=0, `rk_valid`=1.
- Accept on `key_valid && key_ready` (IDLE or DONE):
  - w[0..NK-1] load from `key_in`.
  - Word counter i is set to NK; Rcon is set to 0x01.
  - State goes to EXPAND; `rk_valid` clears.
- EXPAND computes one word per cycle: w[i] = w[i-NK] ^ temp, where temp is:
  - i mod NK == 0: SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}; Rcon is then updated by xtime (multiply by x, mod 0x11B).
  - NK==8 and i mod 8 == 4: SubWord(w[i-1]).
  - otherwise: w[i-1].
- After w[4*NR+3] is written: state goes to DONE and `rk_valid`=1.
- `key_valid` is ignored in EXPAND; the key is not captured and no error is raised.
- A new key accepted in DONE restarts expansion; the old keys are overwritten progressively and `rk_valid` is 0 until the new schedule completes.
- `rk_rd_idx` > NR: `rk_rd_data` = 0.
- Reads while `rk_valid`=0 return current storage contents, which are undefined for use; consumers gate on `rk_valid`.
- i mod NK is tracked by a wrapping sub-counter; no divider is used.

## Timing
- Acceptance edge is cycle 0. Word w[NK+k-1] is written at edge k.
- `rk_valid` rises at edge 4*NR+4-NK: 40 (NK=4), 46 (NK=6), 52 (NK=8).
- `key_ready` returns with `rk_valid` in the same cycle.
- `rk_rd_data` follows `rk_rd_idx` in the same cycle (zero-latency read).
- Reset, asynchronous at any time including mid-EXPAND:
  - State goes to IDLE; all storage, counters and Rcon clear to 0.
  - Outputs: `key_ready`=1, `busy`=0, `rk_valid`=0, `rk_rd_data`=0.
- Reset deassertion is synchronised externally; the first acceptance is possible on the first edge after release.

## Configuration
- `AES_KEYEXP_EQINV_EN` defined: `rk_rd_data` for indices 1..NR-1 is InvMixColumns(round key). This is the equivalent-inverse-cipher schedule; indices 0 and NR are unchanged. The transform is combinational on the read path.
- Macro undefined: plain FIPS-197 schedule for all indices.
- Timing and handshake are identical in both builds.

## Structure
- Shared package `aes_pkg`:
  - S-box table.
  - `xtime` and InvMixColumns-word functions.
  - Type `aes_word_t`.
  - State enum (IDLE, EXPAND, DONE).
  - Constant `AES_RCON_INIT` = 8'h01.
- Sub-module `aes_sbox_word`: combinational SubWord on 32 bits (four S-box lookups), one instance.
- Word storage is a flat register array of 4*(NR+1) words.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c -> `rk_valid` rises at edge 40; idx 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; idx 0 reads the key.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> `rk_valid` at edge 46; idx 12 reads e98ba06f448c773c8ecc720401002202.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> `rk_valid` at edge 52; idx 14 reads fe4890d1e6188d0b046df344706c631e.
- Hold `key_valid`=1 with a different key throughout EXPAND -> `key_ready`=0 and the result still equals the first key's schedule; the second key is accepted only in DONE and `rk_valid` drops one cycle later.
- Assert `rst_n` at edge 20 of an NK=4 expansion -> all outputs at reset values immediately; a fresh key then completes at edge 40 with correct keys.
- `rk_rd_idx`=15 with NK=4 in DONE -> `rk_rd_data`=0. With `AES_KEYEXP_EQINV_EN` defined, idx 5 equals InvMixColumns of the plain idx-5 key from the model, and idx 0 and 10 are unchanged.
